// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle W-bit subtractor (d = a - b - bin), one 4-bit borrow-lookahead slice per clock.
// Optional compare outputs lt/eq/gt are built when SUB_COMPARE_EN is defined.
module nibble_serial_subtractor #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] d,
  output logic                 bout,
  output logic                 ovf
`ifdef SUB_COMPARE_EN
  ,
  output logic                 lt,
  output logic                 eq,
  output logic                 gt
`endif
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_a, r_b, r_d, w_d_new;
  logic          r_borrow, r_bout, r_ovf;
  logic [IW-1:0] r_idx;
  logic [3:0]    w_as, w_bs, w_g, w_p, w_diff;
  logic [4:0]    w_c;
  logic          w_last, w_ovf_new, w_zero;
`ifdef SUB_COMPARE_EN
  logic          r_lt, r_eq, r_gt;
`endif

  assign w_as = r_a[{r_idx, 2'b00} +: 4];
  assign w_bs = r_b[{r_idx, 2'b00} +: 4];
  assign w_g  = ~w_as & w_bs;
  assign w_p  = ~(w_as ^ w_bs);

  // Borrow lookahead: every slice borrow is a flat function of g/p and the slice borrow-in
  assign w_c[0] = r_borrow;
  assign w_c[1] = w_g[0] | (w_p[0] & r_borrow);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);
  assign w_diff = w_as ^ w_bs ^ w_c[3:0];

  always_comb begin
    w_d_new = r_d;
    w_d_new[{r_idx, 2'b00} +: 4] = w_diff;
  end

  assign w_last    = (r_idx == IW'(NIBBLES - 1));
  assign w_ovf_new = (r_a[W-1] ^ r_b[W-1]) & (w_diff[3] ^ r_a[W-1]);
  assign w_zero    = (w_d_new == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_BUSY;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
    d    = r_d;
    bout = r_bout;
    ovf  = r_ovf;
`ifdef SUB_COMPARE_EN
    lt   = r_lt;
    eq   = r_eq;
    gt   = r_gt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef SUB_COMPARE_EN
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_a      <= a;
          r_b      <= b;
          r_borrow <= bin;
          r_idx    <= '0;
          r_d      <= '0;
        end
        S_BUSY: begin
          r_d      <= w_d_new;
          r_borrow <= w_c[4];
          // Index parks on the last slice so it never selects past the operand
          if (w_last) begin
            r_bout <= w_c[4];
            r_ovf  <= w_ovf_new;
`ifdef SUB_COMPARE_EN
            r_lt   <= w_c[4];
            r_eq   <= w_zero & ~w_c[4];
            r_gt   <= ~w_c[4] & ~(w_zero & ~w_c[4]);
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SUB_COMPARE_EN
  logic w_unused;
  assign w_unused = w_zero;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (NIBBLES=4); checks lt/eq/gt when SUB_COMPARE_EN is defined.
module tb_nibble_serial_subtractor;
  localparam int unsigned NIB = 4;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        lt;
    logic        eq;
    logic        gt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a_i = '0, b_i = '0;
  logic        bin_i = 1'b0;
  logic        busy, done, bout, ovf;
  logic [15:0] d;
`ifdef SUB_COMPARE_EN
  logic        lt, eq, gt;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic last_bout = 1'b0;
  vec_t sb[$];
  vec_t tbl[8];

  nibble_serial_subtractor #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .bin(bin_i),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
`ifdef SUB_COMPARE_EN
    , .lt(lt), .eq(eq), .gt(gt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic c);
    vec_t v;
    logic [16:0] t;
    t      = {1'b0, x} - {1'b0, y} - 17'(c);
    v.a    = x;
    v.b    = y;
    v.bin  = c;
    v.d    = t[15:0];
    v.bout = t[16];
    v.ovf  = (x[15] ^ y[15]) & (t[15] ^ x[15]);
    v.lt   = t[16];
    v.eq   = (t[15:0] == 16'h0) && !t[16];
    v.gt   = !v.lt && !v.eq;
    return v;
  endfunction

  // Scoreboard: every done pulse consumes one expected record; no done allowed when empty
  always @(negedge clk) begin
    vec_t e;
    if (sb.size() == 0) begin
      chk("spurious_done", 32'(done), 32'(0));
    end else if (done) begin
      e = sb.pop_front();
      chk("d", 32'(d), 32'(e.d));
      chk("bout", 32'(bout), 32'(e.bout));
      chk("ovf", 32'(ovf), 32'(e.ovf));
`ifdef SUB_COMPARE_EN
      chk("lt", 32'(lt), 32'(e.lt));
      chk("eq", 32'(eq), 32'(e.eq));
      chk("gt", 32'(gt), 32'(e.gt));
`endif
    end
  end

  task automatic run_op(input vec_t v, input bit noise);
    int n;
    bit seen;
    @(negedge clk);
    a_i = v.a; b_i = v.b; bin_i = v.bin; start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    a_i = 16'($urandom); b_i = 16'($urandom); bin_i = 1'($urandom_range(0, 1));
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("d_clear_on_start", 32'(d), 32'(0));
        chk("bout_hold_on_start", 32'(bout), 32'(last_bout));
      end
      chk("busy_high", 32'(busy), 32'(1));
      if (done) seen = 1;
      if (noise) begin
        start = 1'b1;
        a_i = 16'($urandom); b_i = 16'($urandom); bin_i = 1'($urandom_range(0, 1));
      end
    end
    chk("done_seen", 32'(seen), 32'(1));
    chk("latency", 32'(n), 32'(NIB + 1));
    @(negedge clk);
    start = 1'b0;
    chk("busy_low_after", 32'(busy), 32'(0));
    chk("done_low_after", 32'(done), 32'(0));
    last_bout = v.bout;
  endtask

  initial begin
    int t_done[3];
    int nd, guard;
    //             a         b         bin   d         bout  ovf   lt    eq    gt
    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_d", 32'(d), 32'(0));
    chk("rst_bout", 32'(bout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i], 1'b0);
    for (int i = 0; i < 8; i++) run_op(mk(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1))), 1'b0);

    // start re-asserted with other operands during busy/done must be ignored
    run_op(tbl[0], 1'b1);

    // start held high: back-to-back operations every NIB+2 cycles
    @(negedge clk);
    a_i = tbl[7].a; b_i = tbl[7].b; bin_i = tbl[7].bin; start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(tbl[7]);
    nd = 0; guard = 0;
    while (nd < 3 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (done) begin
        t_done[nd] = cyc;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nd), 32'(3));
    if (nd == 3) begin
      chk("b2b_gap1", 32'(t_done[1] - t_done[0]), 32'(NIB + 2));
      chk("b2b_gap2", 32'(t_done[2] - t_done[1]), 32'(NIB + 2));
    end
    @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'(0));
    last_bout = tbl[7].bout;

    // asynchronous reset in the second busy cycle discards the operation
    run_op(tbl[3], 1'b0);
    @(negedge clk);
    a_i = tbl[0].a; b_i = tbl[0].b; bin_i = tbl[0].bin; start = 1'b1;
    sb.push_back(tbl[0]);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_d", 32'(d), 32'(0));
    chk("midrst_bout", 32'(bout), 32'(0));
    chk("midrst_ovf", 32'(ovf), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_bout = 1'b0;
    repeat (3) @(negedge clk);
    run_op(tbl[0], 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
